simd_alu_pipe: RTL and testbench
================================

Name: simd_alu_pipe

Overview:
Parametrised, registered successor to the core ALU, with a SIMD lane width that can be set per instance. It keeps the existing 4-bit op encodings and adds saturating subtract, signed saturating add, signed compare and an iterative per-lane multiply. A valid/ready handshake on both input and output lets it sit as an execute-stage unit that can stall the pipeline.

Parameters:
DATA_W, 32, operand/result width in bits
LANE_W, 8, SIMD lane width; must divide DATA_W, must be ≥2; LANES = DATA_W/LANE_W is a derived localparam

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  operand/op presented
in_ready  out  1  unit accepts this cycle
src_a  in  DATA_W  operand A
src_b  in  DATA_W  operand B
alu_ctrl  in  4  operation select
out_valid  out  1  result register holds an untaken result
out_ready  in  1  consumer takes result this cycle
result  out  DATA_W  registered result
zero  out  1  (result == 0), combinational from the result register
lane_sat  out  LANES  per-lane clamp flags for the current result
sat_sticky  out  1  OR of all lane_sat since last clear
sat_clr  in  1  clears sat_sticky
illegal  out  1  current result came from an undefined alu_ctrl

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE; any multiply in progress is aborted and discarded.
  - out_valid=0, result=0 (so zero=1), lane_sat=0, sat_sticky=0, illegal=0.
- in_ready = rst_n & (state==IDLE) & (!out_valid | out_ready). Accept occurs when in_valid & in_ready at an edge.
- Handshake rules:
  - While out_valid & !out_ready, result, lane_sat and illegal stay stable.
  - When out_valid & out_ready and no new result is written that edge, out_valid drops to 0; result keeps its value.
- Ops; lane i is bits [i*LANE_W +: LANE_W]. Whole-word ops wrap mod 2^DATA_W.
  - 0010: A+B
  - 0110: A-B
  - 0000: A&B
  - 0001: A|B
  - 0011: A^B
  - 0111: unsigned A<B, zero-extended
  - 1101: signed A<B, zero-extended
  - 1000: per-lane add, wrap
  - 1001: per-lane unsigned add; clamps to all-ones on carry-out
  - 1010: per-lane unsigned sub; clamps to 0 on borrow
  - 1011: per-lane signed add; clamps to +max/-min on overflow
  - 1100: per-lane unsigned multiply, low LANE_W bits of the product; never sets lane_sat
  - Any other code: result=0, illegal=1, single-cycle.
- lane_sat[i]=1 iff lane i was clamped. It is 0 for all non-saturating ops and is written together with result.
- sat_sticky:
  - Set at any result write with a nonzero lane_sat.
  - Cleared by sat_clr=1 at an edge.
  - If set and clear happen on the same edge, set wins.
- Single-cycle ops (everything except 1100):
  - The result is written at the accept edge, so out_valid is high the next cycle.
  - Throughput is one op per cycle while out_ready=1.
- Multiply FSM:
  - IDLE -> MUL on accept of 1100. Operands are latched and a counter set to 0.
  - In MUL, one shift-add step per edge runs in all lanes in parallel.
  - After LANE_W MUL edges, the result is written, out_valid=1, and state returns to IDLE.
  - out_valid therefore rises LANE_W edges after the accept edge, and in_ready=0 throughout MUL.
  - The output register is always free at completion, because accept required !out_valid or a simultaneous take.
- Operands are sampled only at the accept edge; changes to src_a, src_b or alu_ctrl at other times have no effect.

Test Plan:
1. Reset:
   - Stimulus: rst_n=0 for 2 cycles with in_valid=1.
   - Required: in_ready=0, out_valid=0, result=0, zero=1, sat_sticky=0; first op after release is accepted normally.
2. Saturating adds, LANE_W=8, A=0x7F80FF01, B=0x01800102:
   - Op 1001 -> result 0x80FFFF03, lane_sat=0110, sat_sticky=1.
   - Op 1011 -> result 0x7F800003, lane_sat=1100.
   - Op 1000 -> result 0x80000003, lane_sat=0000.
   - sat_clr pulse clears sat_sticky.
3. Multiply 1100, A=0x0310FF02, B=0x05100203:
   - Result 0x0F00FE06, lane_sat=0.
   - out_valid rises exactly 8 edges after accept; in_ready=0 during MUL.
4. Backpressure:
   - Stimulus: issue three adds (1+1, 2+2, 3+3) with out_ready=0 for 5 cycles, then out_ready=1.
   - Required: result held at 2 while stalled; in_ready=0 while stalled; results 2, 4, 6 delivered in order, none lost.
5. Compares and illegal code, A=0x00000001, B=0xFFFFFFFF:
   - Op 0111 -> result 1, zero=0.
   - Op 1101 -> result 0, zero=1.
   - Op 1111 -> result 0, illegal=1, out_valid=1 next cycle.
6. Reset mid-multiply:
   - Stimulus: assert rst_n=0 three cycles into MUL.
   - Required: out_valid=0 and state IDLE; the next op 0010 (5+7) returns 12 one cycle after accept.

Source files
------------

// File: rtl/simd_alu_pipe.sv
// simd_alu_pipe: registered SIMD ALU with valid/ready handshake and an iterative per-lane multiply
module simd_alu_pipe #(
  parameter int DATA_W = 32,
  parameter int LANE_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          src_a,
  input  logic [DATA_W-1:0]          src_b,
  input  logic [3:0]                 alu_ctrl,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          result,
  output logic                       zero,
  output logic [DATA_W/LANE_W-1:0]   lane_sat,
  output logic                       sat_sticky,
  input  logic                       sat_clr,
  output logic                       illegal
);
  localparam int LANES = DATA_W / LANE_W;
  localparam int CW = $clog2(LANE_W);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] ma, mb, acc, ma_n, mb_n, acc_n;
  logic [DATA_W-1:0] ladd, lsadd, lssub, lsgn, res_n;
  logic [LANES-1:0] cadd, csub, csgn, sat_n;
  logic ill_n, accept, is_mul, done, wr;
  assign in_ready = rst_n & (state == IDLE) & (~out_valid | out_ready);
  assign accept = in_valid & in_ready;
  assign is_mul = alu_ctrl == 4'b1100;
  assign done = (state == MUL) && (cnt == CW'(LANE_W - 1));
  assign wr = (accept && !is_mul) || done;
  assign zero = ~|result;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_W-1:0] a, b, pa, pb, pc;
    logic [LANE_W:0] s, d;
    logic ov;
    assign a = src_a[i*LANE_W +: LANE_W];
    assign b = src_b[i*LANE_W +: LANE_W];
    assign s = {1'b0, a} + {1'b0, b};
    assign d = {1'b0, a} - {1'b0, b};
    assign ov = (a[LANE_W-1] == b[LANE_W-1]) && (s[LANE_W-1] != a[LANE_W-1]);
    assign ladd[i*LANE_W +: LANE_W] = s[LANE_W-1:0];
    assign lsadd[i*LANE_W +: LANE_W] = s[LANE_W] ? '1 : s[LANE_W-1:0];
    assign lssub[i*LANE_W +: LANE_W] = d[LANE_W] ? '0 : d[LANE_W-1:0];
    // signed overflow clamps toward the sign of the operands
    assign lsgn[i*LANE_W +: LANE_W] = ov ? {a[LANE_W-1], {(LANE_W-1){~a[LANE_W-1]}}} : s[LANE_W-1:0];
    assign cadd[i] = s[LANE_W];
    assign csub[i] = d[LANE_W];
    assign csgn[i] = ov;
    assign pa = ma[i*LANE_W +: LANE_W];
    assign pb = mb[i*LANE_W +: LANE_W];
    assign pc = acc[i*LANE_W +: LANE_W];
    assign acc_n[i*LANE_W +: LANE_W] = pc + (pb[0] ? pa : '0);
    assign ma_n[i*LANE_W +: LANE_W] = {pa[LANE_W-2:0], 1'b0};
    assign mb_n[i*LANE_W +: LANE_W] = {1'b0, pb[LANE_W-1:1]};
  end
  always_comb begin
    res_n = '0;
    sat_n = '0;
    ill_n = 1'b0;
    if (done) res_n = acc_n;
    else
      case (alu_ctrl)
        4'b0010: res_n = src_a + src_b;
        4'b0110: res_n = src_a - src_b;
        4'b0000: res_n = src_a & src_b;
        4'b0001: res_n = src_a | src_b;
        4'b0011: res_n = src_a ^ src_b;
        4'b0111: res_n = DATA_W'(src_a < src_b);
        4'b1101: res_n = DATA_W'($signed(src_a) < $signed(src_b));
        4'b1000: res_n = ladd;
        4'b1001: begin res_n = lsadd; sat_n = cadd; end
        4'b1010: begin res_n = lssub; sat_n = csub; end
        4'b1011: begin res_n = lsgn; sat_n = csgn; end
        4'b1100: res_n = '0;
        default: ill_n = 1'b1;
      endcase
  end
  always_comb state_n = (accept && is_mul) ? MUL : done ? IDLE : state;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (!rst_n) begin
      out_valid <= 1'b0;
      result <= '0;
      lane_sat <= '0;
      sat_sticky <= 1'b0;
      illegal <= 1'b0;
      cnt <= '0;
      ma <= '0;
      mb <= '0;
      acc <= '0;
    end else begin
      out_valid <= wr | (out_valid & ~out_ready);
      if (wr) begin
        result <= res_n;
        lane_sat <= sat_n;
        illegal <= ill_n;
      end
      sat_sticky <= (wr & |sat_n) | (sat_sticky & ~sat_clr);
      if (accept) begin
        ma <= src_a;
        mb <= src_b;
        acc <= '0;
        cnt <= '0;
      end else if (state == MUL) begin
        ma <= ma_n;
        mb <= mb_n;
        acc <= acc_n;
        cnt <= cnt + CW'(1);
      end
    end
endmodule

// File: tb/tb_simd_alu_pipe.sv
// tb_simd_alu_pipe: directed self-checking bench for simd_alu_pipe (DATA_W=32, LANE_W=8)
module tb_simd_alu_pipe;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, zero, sat_sticky, sat_clr, illegal;
  logic [31:0] src_a, src_b, result;
  logic [3:0] alu_ctrl, lane_sat;
  int checks = 0;
  int errors = 0;
  int n;

  simd_alu_pipe #(.DATA_W(32), .LANE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .src_a(src_a), .src_b(src_b), .alu_ctrl(alu_ctrl), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .lane_sat(lane_sat),
    .sat_sticky(sat_sticky), .sat_clr(sat_clr), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    src_a = a;
    src_b = b;
    alu_ctrl = op;
    in_valid = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
    issue(32'h1, 32'h1, 4'b0010);
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_sticky", sat_sticky, 0);
    check("rst_lane_sat", lane_sat, 0);
    check("rst_illegal", illegal, 0);

    rst_n = 1'b1;
    issue(32'h7F80FF01, 32'h01800102, 4'b1001);
    #1 check("rel_in_ready", in_ready, 1);
    tick();
    check("usat_valid", out_valid, 1);
    check("usat_result", result, 32'h80FFFF03);
    check("usat_lane_sat", lane_sat, 4'b0110);
    check("usat_sticky", sat_sticky, 1);
    alu_ctrl = 4'b1011;
    tick();
    check("ssat_result", result, 32'h7F800003);
    check("ssat_lane_sat", lane_sat, 4'b1100);
    alu_ctrl = 4'b1000;
    tick();
    check("wadd_result", result, 32'h80000003);
    check("wadd_lane_sat", lane_sat, 4'b0000);
    check("wadd_sticky", sat_sticky, 1);
    alu_ctrl = 4'b1001; sat_clr = 1'b1;
    tick();
    check("setwins_sticky", sat_sticky, 1);
    in_valid = 1'b0;
    tick();
    check("clr_sticky", sat_sticky, 0);
    check("clr_out_valid", out_valid, 0);
    check("clr_result_kept", result, 32'h80FFFF03);
    sat_clr = 1'b0;

    issue(32'hF0F01234, 32'h0FF05678, 4'b0010);
    tick(); check("add", result, 32'h00E068AC);
    alu_ctrl = 4'b0110; tick(); check("sub", result, 32'hE0FFBBBC);
    alu_ctrl = 4'b0000; tick(); check("and", result, 32'h00F01230);
    alu_ctrl = 4'b0001; tick(); check("or", result, 32'hFFF0567C);
    alu_ctrl = 4'b0011; tick(); check("xor", result, 32'hFF00444C);
    alu_ctrl = 4'b1010; tick(); check("usub_result", result, 32'hE1000000);
    check("usub_lane_sat", lane_sat, 4'b0011);
    in_valid = 1'b0; sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;

    issue(32'h0310FF02, 32'h05100203, 4'b1100);
    tick();
    issue(32'hDEADBEEF, 32'h12345678, 4'b0010);
    n = 0;
    while (!out_valid && n < 20) begin
      check("mul_in_ready", in_ready, 0);
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("mul_latency", n, 8);
    check("mul_result", result, 32'h0F00FE06);
    check("mul_lane_sat", lane_sat, 0);
    check("mul_in_ready_done", in_ready, 1);
    tick();
    check("mul_taken", out_valid, 0);

    out_ready = 1'b0;
    issue(32'd1, 32'd1, 4'b0010);
    #1 check("bp_first_ready", in_ready, 1);
    tick();
    check("bp_first_valid", out_valid, 1);
    check("bp_first_result", result, 2);
    issue(32'd2, 32'd2, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      #1 check("bp_stall_ready", in_ready, 0);
      tick();
      check("bp_stall_result", result, 2);
      check("bp_stall_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", in_ready, 1);
    check("bp_deliver_2", result, 2);
    tick();
    check("bp_deliver_4", result, 4);
    issue(32'd3, 32'd3, 4'b0010);
    tick();
    check("bp_deliver_6", result, 6);
    check("bp_valid_6", out_valid, 1);
    in_valid = 1'b0;
    tick();
    check("bp_drained", out_valid, 0);
    check("bp_result_kept", result, 6);

    issue(32'h1, 32'hFFFFFFFF, 4'b0111);
    tick();
    check("sltu_result", result, 1);
    check("sltu_zero", zero, 0);
    check("sltu_illegal", illegal, 0);
    alu_ctrl = 4'b1101;
    tick();
    check("slt_result", result, 0);
    check("slt_zero", zero, 1);
    alu_ctrl = 4'b1111;
    tick();
    check("ill_result", result, 0);
    check("ill_flag", illegal, 1);
    check("ill_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();

    issue(32'h3, 32'h5, 4'b1100);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    check("mrst_out_valid", out_valid, 0);
    check("mrst_result", result, 0);
    rst_n = 1'b1;
    issue(32'd5, 32'd7, 4'b0010);
    #1 check("mrst_idle_ready", in_ready, 1);
    tick();
    check("mrst_add_valid", out_valid, 1);
    check("mrst_add_result", result, 12);
    in_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) n++;
    end
    check("mrst_no_stale", n, 0);
    check("mrst_result_kept", result, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
